lvg_seq: RTL and testbench

- Hardware command sequencer that drives the lvg 4x4 fp32 matrix unit.
- Accepts a matrix-op request (L, R, A operands plus opcode) on a valid/ready port and issues the lvg instruction sequence: load R/A, load L, execute and hold for the compute latency.
- Captures the B matrix and returns it on a valid/ready response port.
- Sits between a host/DMA command queue and the lvg instance, replacing bench-driven instruction sequencing.

---
 rtl/lvg_seq.sv | 151 +++++++++++++++
 tb/tb_lvg_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lvg_seq.sv
// lvg_seq: command sequencer for the lvg 4x4 fp32 matrix unit.
// Takes a matrix-op request, issues load R/A, load L and compute to lvg, and returns B.
module lvg_seq #(
  parameter int unsigned LATENCY    = 16,
  parameter logic [7:0]  OP_LOAD_L  = 8'd1,
  parameter logic [7:0]  OP_LOAD_RA = 8'd2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_op,
  input  logic         req_keep_ra,
  input  logic [511:0] req_l,
  input  logic [511:0] req_r,
  input  logic [511:0] req_a,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_err,
  output logic [511:0] rsp_b,
  output logic [7:0]   lvg_instr,
  output logic [511:0] lvg_l,
  output logic [511:0] lvg_r,
  output logic [511:0] lvg_a,
  input  logic [511:0] lvg_b,
  output logic         busy
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_RA = 3'd1,
    LD_L  = 3'd2,
    EXEC  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [7:0]     op_r;
  logic [511:0]   l_r;
  logic [7:0]     instr_nxt_s;
  logic           accept_s;
  logic           exec_done_s;

  // Opcodes that would clobber lvg operand state (or do nothing) are rejected.
  function automatic logic is_illegal(input logic [7:0] op);
    is_illegal = (op == 8'd0) || (op == OP_LOAD_L) || (op == OP_LOAD_RA);
  endfunction

  assign accept_s    = req_valid && req_ready;
  assign exec_done_s = (state_r == EXEC) && (cnt_r == {CW{1'b0}});

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (is_illegal(req_op)) begin
          state_nxt_s = RESP;
        end else if (req_keep_ra) begin
          state_nxt_s = LD_L;
        end else begin
          state_nxt_s = LD_RA;
        end
      end
      LD_RA:   state_nxt_s = LD_L;
      LD_L:    state_nxt_s = EXEC;
      EXEC: begin
        if (exec_done_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Instruction for the state being entered, so lvg_instr is a plain register.
  always_comb begin
    instr_nxt_s = 8'd0;
    case (state_nxt_s)
      LD_RA:   instr_nxt_s = OP_LOAD_RA;
      LD_L:    instr_nxt_s = OP_LOAD_L;
      EXEC:    instr_nxt_s = op_r;
      default: instr_nxt_s = 8'd0;
    endcase
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 8'd0;
      l_r       <= 512'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_b     <= 512'd0;
      lvg_instr <= 8'd0;
      lvg_l     <= 512'd0;
      lvg_r     <= 512'd0;
      lvg_a     <= 512'd0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      lvg_instr <= instr_nxt_s;
      req_ready <= (state_nxt_s == IDLE);
      busy      <= (state_nxt_s != IDLE);
      rsp_valid <= (state_nxt_s == RESP);
      if (accept_s) begin
        op_r <= req_op;
        l_r  <= req_l;
      end
      // LD_RA is only entered straight from an accept, so the request bus is still valid.
      if (state_nxt_s == LD_RA) begin
        lvg_r <= req_r;
        lvg_a <= req_a;
      end
      if (state_nxt_s == LD_L) begin
        lvg_l <= (state_r == IDLE) ? req_l : l_r;
      end
      if (state_r == LD_L) begin
        cnt_r <= CW'(LATENCY - 1);
      end else if ((state_r == EXEC) && !exec_done_s) begin
        cnt_r <= cnt_r - CW'(1);
      end
      if (accept_s && is_illegal(req_op)) begin
        rsp_err <= 1'b1;
        rsp_b   <= 512'd0;
      end else if (exec_done_s) begin
        rsp_err <= 1'b0;
        rsp_b   <= lvg_b;
      end
    end
  end

endmodule

// File: tb/tb_lvg_seq.sv
// Self-checking bench for lvg_seq: directed ops against a stub lvg whose B output
// changes every cycle, so the capture cycle of rsp_b is pinned exactly.
module tb_lvg_seq;
  localparam int LAT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_op;
  logic         req_keep_ra;
  logic [511:0] req_l, req_r, req_a;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_err;
  logic [511:0] rsp_b;
  logic [7:0]   lvg_instr;
  logic [511:0] lvg_l, lvg_r, lvg_a, lvg_b;
  logic         busy;

  logic [31:0]  cyc = 32'd0;

  typedef struct packed {
    logic         err;
    logic [511:0] b;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [511:0] last_r, last_a;
  logic [511:0] l0, r0, a0, l1, r1, a1;

  lvg_seq #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_keep_ra(req_keep_ra), .req_l(req_l), .req_r(req_r), .req_a(req_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_b(rsp_b),
    .lvg_instr(lvg_instr), .lvg_l(lvg_l), .lvg_r(lvg_r), .lvg_a(lvg_a),
    .lvg_b(lvg_b), .busy(busy)
  );

  function automatic logic [511:0] pat(input logic [31:0] c);
    return {16{c ^ 32'hA5A5_0000}};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign lvg_b = pat(cyc);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lvg_instr in cycle k after the accept edge (cycle lat is the first RESP cycle).
  function automatic logic [7:0] exp_instr(input int k, input int lat, input logic keep,
                                           input logic ill, input logic [7:0] op);
    int first_exec;
    if (ill || k >= lat) return 8'd0;
    first_exec = keep ? 2 : 3;
    if (k >= first_exec) return op;
    if (k == first_exec - 1) return 8'd1;
    return 8'd2;
  endfunction

  // Called and returns right after a falling edge.
  task automatic do_op(input string tag, input logic [7:0] op, input logic keep,
                       input logic [511:0] l, input logic [511:0] r, input logic [511:0] a,
                       input int stall);
    int          lat;
    logic        ill;
    logic [31:0] ca;
    exp_t        e;
    ill = (op == 8'd0) || (op == 8'd1) || (op == 8'd2);
    lat = ill ? 1 : (keep ? LAT + 2 : LAT + 3);
    chk1({tag, "/req_ready"}, req_ready, 1'b1);
    req_op = op; req_keep_ra = keep; req_l = l; req_r = r; req_a = a;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    ca = cyc;
    e.err = ill;
    e.b   = ill ? 512'd0 : pat(ca + 32'(lat) - 32'd1);
    sb.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_op = 8'hFF; req_l = ~l; req_r = ~r; req_a = ~a;
      end
      chk8({tag, "/instr"}, lvg_instr, exp_instr(k, lat, keep, ill, op));
      chk1({tag, "/rsp_valid"}, rsp_valid, k == lat);
      chk1({tag, "/busy"}, busy, 1'b1);
      if (!ill && !keep && k == 1) begin
        chkw({tag, "/lvg_r"}, lvg_r, r);
        chkw({tag, "/lvg_a"}, lvg_a, a);
      end
      if (!ill && keep && k == 1) begin
        chkw({tag, "/lvg_r_kept"}, lvg_r, last_r);
        chkw({tag, "/lvg_a_kept"}, lvg_a, last_a);
      end
      if (!ill && k == (keep ? 1 : 2)) chkw({tag, "/lvg_l"}, lvg_l, l);
    end
    if (!ill && !keep) begin
      last_r = r;
      last_a = a;
    end
    for (int s = 0; s < stall; s++) begin
      chk1({tag, "/stall_valid"}, rsp_valid, 1'b1);
      chk1({tag, "/stall_ready"}, req_ready, 1'b0);
      chk8({tag, "/stall_instr"}, lvg_instr, 8'd0);
      chkw({tag, "/stall_b"}, rsp_b, e.b);
      chk1({tag, "/stall_err"}, rsp_err, e.err);
      req_valid = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s/scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chkw({tag, "/rsp_b"}, rsp_b, e.b);
      chk1({tag, "/rsp_err"}, rsp_err, e.err);
    end
    @(negedge clk);
    chk1({tag, "/valid_drop"}, rsp_valid, 1'b0);
    chk1({tag, "/ready_back"}, req_ready, 1'b1);
    chk1({tag, "/busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    l0 = {{14{32'h4000_0000}}, 32'h3f80_0000, 32'h3f80_0000};
    r0 = {{15{32'h3e80_0000}}, 32'h3fce_5aee};
    a0 = {{15{32'hbf00_0000}}, 32'hbfd2_cfe4};
    l1 = {16{32'h1234_5678}};
    r1 = {16{32'h0bad_f00d}};
    a1 = {16{32'h5555_aaaa}};
    last_r = 512'd0; last_a = 512'd0;

    rst = 1'b0; req_valid = 1'b1; req_op = 8'd8; req_keep_ra = 1'b0;
    req_l = l0; req_r = r0; req_a = a0; rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("reset/rsp_valid", rsp_valid, 1'b0);
      chk8("reset/instr", lvg_instr, 8'd0);
      chk1("reset/busy", busy, 1'b0);
    end
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk1("reset/req_ready", req_ready, 1'b1);
    chk1("reset/busy_after", busy, 1'b0);
    chkw("reset/rsp_b", rsp_b, 512'd0);

    do_op("full", 8'd8, 1'b0, l0, r0, a0, 0);
    do_op("keep", 8'd6, 1'b1, l1, r1, a1, 0);
    do_op("ill2", 8'd2, 1'b0, l1, r1, a1, 0);
    do_op("ill0", 8'd0, 1'b1, l1, r1, a1, 0);
    do_op("bp", 8'd8, 1'b0, l1, r1, a1, 10);
    do_op("after_bp", 8'd5, 1'b0, l0, r0, a0, 0);

    // Reset while in EXEC cycle 5: no response may ever appear for that request.
    chk1("abort/req_ready", req_ready, 1'b1);
    req_op = 8'd8; req_keep_ra = 1'b0; req_l = l1; req_r = r1; req_a = a1;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk8("abort/instr_exec", lvg_instr, 8'd8);
    rst = 1'b0;
    @(negedge clk);
    chk8("abort/instr", lvg_instr, 8'd0);
    chk1("abort/busy", busy, 1'b0);
    chk1("abort/rsp_valid", rsp_valid, 1'b0);
    chkw("abort/lvg_r", lvg_r, 512'd0);
    rst = 1'b1;
    last_r = 512'd0; last_a = 512'd0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      chk1("abort/no_rsp", rsp_valid, 1'b0);
    end
    do_op("post_abort", 8'd7, 1'b1, l0, r0, a0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
